mem_access_unit: RTL and testbench

MEM-stage data-memory access unit: the consumer of the memory control bits that the EX/MEM pipeline register delivers (Size, Enable, rw, Load). It turns one decoded memory operation into a request/acknowledge transaction on the data-memory port. It handles byte lanes for word and byte accesses, stalls the pipeline while the memory is busy, and drives the write-back data (memory read data or the pass-through ALU result).

---
 rtl/mem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: IDLE/REQ/DONE request-acknowledge FSM with byte lanes.
// Optional misaligned-word detection is compiled in with `define MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Size_In,
  input  logic              Enable_In,
  input  logic              rw_In,
  input  logic              Load_In,
  input  logic [ADDR_W-1:0] Addr_In,
  input  logic [31:0]       WData_In,
  output logic              Stall_Out,
  output logic [31:0]       Wb_Data_Out,
  output logic              Mem_Req_Out,
  output logic              Mem_We_Out,
  output logic [ADDR_W-1:0] Mem_Addr_Out,
  output logic [3:0]        Mem_Be_Out,
  output logic [31:0]       Mem_WData_Out,
  input  logic [31:0]       Mem_RData_In,
  input  logic              Mem_Ack_In,
  output logic              Err_Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              size_q, size_d;
  logic              rw_q, rw_d;
  logic              load_q, load_d;
  logic [1:0]        lane_q, lane_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              misaligned_s;

  function automatic logic [3:0] byte_enables(input logic is_byte, input logic [1:0] lane);
    if (is_byte) begin
      byte_enables = 4'b0001 << lane;
    end else begin
      byte_enables = 4'hF;
    end
  endfunction

  // Read data is shifted down from its lane and zero-extended for byte loads
  function automatic logic [31:0] extract_lane(input logic [31:0] data, input logic is_byte,
                                               input logic [1:0] lane);
    if (is_byte) begin
      case (lane)
        2'd0:    extract_lane = {24'h000000, data[7:0]};
        2'd1:    extract_lane = {24'h000000, data[15:8]};
        2'd2:    extract_lane = {24'h000000, data[23:16]};
        2'd3:    extract_lane = {24'h000000, data[31:24]};
        default: extract_lane = 32'h00000000;
      endcase
    end else begin
      extract_lane = data;
    end
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_s = ~Size_In & (Addr_In[1:0] != 2'b00);
`else
  assign misaligned_s = 1'b0;
`endif

  // Next-state and registered memory-port values
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    rw_d        = rw_q;
    load_d      = load_q;
    lane_d      = lane_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (Enable_In) begin
          size_d = Size_In;
          rw_d   = rw_In;
          load_d = Load_In;
          lane_d = Addr_In[1:0];
          if (misaligned_s) begin
            state_d   = DONE;
            err_d     = 1'b1;
            rdata_d   = 32'h00000000;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = rw_In;
            mem_addr_d  = {Addr_In[ADDR_W-1:2], 2'b00};
            mem_be_d    = byte_enables(Size_In, Addr_In[1:0]);
            mem_wdata_d = Size_In ? {4{WData_In[7:0]}} : WData_In;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (Mem_Ack_In) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!rw_q) begin
            rdata_d = extract_lane(Mem_RData_In, size_q, lane_q);
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous active-low clear
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q     <= IDLE;
      size_q      <= 1'b0;
      rw_q        <= 1'b0;
      load_q      <= 1'b0;
      lane_q      <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h00000000;
      rdata_q     <= 32'h00000000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      rw_q        <= rw_d;
      load_q      <= load_d;
      lane_q      <= lane_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Stall is combinational so the pipeline freezes in the cycle the access appears
  assign Stall_Out     = ((state_q == IDLE) & Enable_In) | (state_q == REQ);
  assign Wb_Data_Out   = ((state_q == DONE) & load_q & ~rw_q) ? rdata_q : 32'(Addr_In);
  assign Mem_Req_Out   = mem_req_q;
  assign Mem_We_Out    = mem_we_q;
  assign Mem_Addr_Out  = mem_addr_q;
  assign Mem_Be_Out    = mem_be_q;
  assign Mem_WData_Out = mem_wdata_q;
  assign Err_Out       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written corner
// sequences and randomized transactions checked against a transaction-level model.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        CLR, Size_In, Enable_In, rw_In, Load_In, Mem_Ack_In;
  logic [31:0] Addr_In, WData_In, Mem_RData_In;
  logic        Stall_Out, Mem_Req_Out, Mem_We_Out, Err_Out;
  logic [31:0] Wb_Data_Out, Mem_Addr_Out, Mem_WData_Out;
  logic [3:0]  Mem_Be_Out;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .CLK(CLK), .CLR(CLR), .Size_In(Size_In), .Enable_In(Enable_In), .rw_In(rw_In),
    .Load_In(Load_In), .Addr_In(Addr_In), .WData_In(WData_In), .Stall_Out(Stall_Out),
    .Wb_Data_Out(Wb_Data_Out), .Mem_Req_Out(Mem_Req_Out), .Mem_We_Out(Mem_We_Out),
    .Mem_Addr_Out(Mem_Addr_Out), .Mem_Be_Out(Mem_Be_Out), .Mem_WData_Out(Mem_WData_Out),
    .Mem_RData_In(Mem_RData_In), .Mem_Ack_In(Mem_Ack_In), .Err_Out(Err_Out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        size;
    logic        rw;
    logic        load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] wb;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour from the access rules: lanes are little-endian bytes of a word
  function automatic vec_t model(input logic size, input logic rw, input logic load,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int waits);
    vec_t v;
    int   lane;
    logic [31:0] rd;
    lane     = int'(addr % 32'd4);
    v.size   = size; v.rw = rw; v.load = load; v.addr = addr;
    v.wdata  = wdata; v.rdata = rdata; v.waits = waits;
    v.maddr  = addr - (addr % 32'd4);
    v.be     = size ? 4'(1 << lane) : 4'hF;
    v.mwdata = size ? (wdata % 32'd256) * 32'h01010101 : wdata;
    rd       = size ? (rdata / (32'd1 << (8 * lane))) % 32'd256 : rdata;
    v.wb     = (!rw && load) ? rd : addr;
    return v;
  endfunction

  // Entered and left just after a rising edge with the FSM in IDLE
  task automatic run_txn(input vec_t v, input string nm);
    int stalls;
    stalls    = 0;
    Enable_In = 1'b1; Size_In = v.size; rw_In = v.rw; Load_In = v.load;
    Addr_In   = v.addr; WData_In = v.wdata; Mem_Ack_In = 1'b0; Mem_RData_In = 32'h0;
    @(negedge CLK);
    chk({nm, " idle_req"}, 32'(Mem_Req_Out), 32'h0);
    if (Stall_Out) stalls++;
    for (int r = 0; r <= v.waits; r++) begin
      @(posedge CLK); #1;
      Mem_Ack_In   = (r == v.waits);
      Mem_RData_In = (r == v.waits) ? v.rdata : $urandom;
      @(negedge CLK);
      chk({nm, " req"},   32'(Mem_Req_Out), 32'h1);
      chk({nm, " we"},    32'(Mem_We_Out), 32'(v.rw));
      chk({nm, " addr"},  Mem_Addr_Out, v.maddr);
      chk({nm, " be"},    32'(Mem_Be_Out), 32'(v.be));
      chk({nm, " wdata"}, Mem_WData_Out, v.mwdata);
      chk({nm, " req_wb"}, Wb_Data_Out, v.addr);
      if (Stall_Out) stalls++;
    end
    @(posedge CLK); #1;
    Mem_Ack_In = 1'b0; Mem_RData_In = $urandom;
    @(negedge CLK);
    chk({nm, " done_req"}, 32'(Mem_Req_Out), 32'h0);
    chk({nm, " done_wb"},  Wb_Data_Out, v.wb);
    chk({nm, " done_err"}, 32'(Err_Out), 32'h0);
    if (Stall_Out) stalls++;
    chk({nm, " stall_cycles"}, 32'(stalls), 32'(v.waits + 2));
    @(posedge CLK); #1;
    Enable_In = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h100};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 32'h11223344, 0, 4'b0100, 32'h100, 32'h0, 32'h22};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h103, 32'hA5, 32'h0, 0, 4'b1000, 32'h100, 32'hA5A5A5A5, 32'h103};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h200, 32'h0, 32'hCAFEF00D, 2, 4'hF, 32'h200, 32'h0, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 32'h12345678, 0, 4'hF, 32'h204, 32'h0, 32'h204};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h301, 32'h1234, 32'h0, 1, 4'b0010, 32'h300, 32'h34343434, 32'h301};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 32'hAABBCCDD, 0, 4'b0001, 32'h10, 32'h0, 32'hDD};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 32'hAABBCCDD, 3, 4'b1000, 32'h10, 32'h0, 32'hAA};

    CLR = 1'b0; Enable_In = 1'b0; Size_In = 1'b0; rw_In = 1'b0; Load_In = 1'b0;
    Addr_In = 32'h55; WData_In = 32'h0; Mem_RData_In = 32'h0; Mem_Ack_In = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req",   32'(Mem_Req_Out), 32'h0);
    chk("rst_we",    32'(Mem_We_Out), 32'h0);
    chk("rst_be",    32'(Mem_Be_Out), 32'h0);
    chk("rst_addr",  Mem_Addr_Out, 32'h0);
    chk("rst_wdata", Mem_WData_Out, 32'h0);
    chk("rst_err",   32'(Err_Out), 32'h0);
    chk("rst_stall", 32'(Stall_Out), 32'h0);
    chk("rst_wb",    Wb_Data_Out, 32'h55);
    @(posedge CLK); #1;
    CLR = 1'b1;

    // Non-memory op with a stray ack: nothing happens
    Addr_In = 32'h1234; Mem_Ack_In = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("nomem_stall", 32'(Stall_Out), 32'h0);
      chk("nomem_wb",    Wb_Data_Out, 32'h1234);
      chk("nomem_req",   32'(Mem_Req_Out), 32'h0);
      @(posedge CLK); #1;
    end
    Mem_Ack_In = 1'b0;

    // Directed table, issued back-to-back
    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Clear during REQ, then a late ack must be ignored
    Enable_In = 1'b1; Size_In = 1'b0; rw_In = 1'b1; Load_In = 1'b0;
    Addr_In = 32'h400; WData_In = 32'h87654321;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("clr_req_before", 32'(Mem_Req_Out), 32'h1);
    CLR = 1'b0; Enable_In = 1'b0;
    @(posedge CLK); #1;
    CLR = 1'b1; Mem_Ack_In = 1'b1; Mem_RData_In = 32'hFFFFFFFF;
    @(negedge CLK);
    chk("clr_req_after", 32'(Mem_Req_Out), 32'h0);
    chk("clr_stall",     32'(Stall_Out), 32'h0);
    chk("clr_be",        32'(Mem_Be_Out), 32'h0);
    chk("clr_we",        32'(Mem_We_Out), 32'h0);
    @(posedge CLK); #1;
    Mem_Ack_In = 1'b0;
    @(negedge CLK);
    chk("late_ack_req",   32'(Mem_Req_Out), 32'h0);
    chk("late_ack_stall", 32'(Stall_Out), 32'h0);
    chk("late_ack_wb",    Wb_Data_Out, 32'h400);
    @(posedge CLK); #1;
    run_txn(model(1'b0, 1'b0, 1'b1, 32'h500, 32'h0, 32'h0BADF00D, 0), "after_clr");

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word read: straight to DONE with an error pulse and zero data
    Enable_In = 1'b1; Size_In = 1'b0; rw_In = 1'b0; Load_In = 1'b1; Addr_In = 32'h101;
    Mem_Ack_In = 1'b0;
    @(negedge CLK);
    chk("mis_stall0", 32'(Stall_Out), 32'h1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mis_req",    32'(Mem_Req_Out), 32'h0);
    chk("mis_err",    32'(Err_Out), 32'h1);
    chk("mis_wb",     Wb_Data_Out, 32'h0);
    chk("mis_stall1", 32'(Stall_Out), 32'h0);
    @(posedge CLK); #1;
    Enable_In = 1'b0;
    @(negedge CLK);
    chk("mis_err_end", 32'(Err_Out), 32'h0);
    chk("mis_req_end", 32'(Mem_Req_Out), 32'h0);
    @(posedge CLK); #1;
`else
    // Misaligned word access is forced aligned
    run_txn(model(1'b0, 1'b0, 1'b1, 32'h105, 32'h0, 32'h5A5A1234, 1), "unaligned_word");
    run_txn(model(1'b0, 1'b1, 1'b0, 32'h10A, 32'h13572468, 32'h0, 0), "unaligned_wr");
`endif

    // Randomized transactions against the transaction-level model
    for (int i = 0; i < 40; i++) begin
      logic        sz, rw, ld;
      logic [31:0] a;
      sz = 1'($urandom_range(1, 0));
      rw = 1'($urandom_range(1, 0));
      ld = 1'($urandom_range(1, 0));
      a  = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      if (!sz) a = a & 32'hFFFFFFFC;
`endif
      run_txn(model(sz, rw, ld, a, $urandom, $urandom, int'($urandom_range(3, 0))),
              $sformatf("rnd%0d", i));
      if ($urandom_range(1, 0) == 1) begin
        Addr_In = $urandom;
        @(negedge CLK);
        chk("rnd_gap_stall", 32'(Stall_Out), 32'h0);
        @(posedge CLK); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
